lin_tx_frame_fifo: RTL

//   Parametrised synchronous FIFO that buffers LIN TX payload words between the
//   APB register interface (writer) and the LIN transmit engine (reader).
//   It replaces the flat addressed TX memory with a first-in/first-out buffer.
//   It adds occupancy tracking, full/empty/almost-full status, a flush control,
//   and sticky overflow/underflow error flags readable over APB.
//

---
 rtl/lin_tx_frame_fifo_if.sv | 32 +++
 rtl/lin_tx_frame_fifo.sv | 112 +++++++++++
 2 files changed

// File: rtl/lin_tx_frame_fifo_if.sv
// Writer/reader handshake and status bundle for the LIN TX payload FIFO.
// The writer side (APB registers or bench) uses master; the FIFO uses slave.
interface lin_tx_frame_fifo_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              err_clr;
    logic              ovf_err;
    logic              unf_err;

    modport master (
        output flush, wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, count, full, empty, almost_full, ovf_err, unf_err
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, count, full, empty, almost_full, ovf_err, unf_err
    );
endinterface

// File: rtl/lin_tx_frame_fifo.sv
// Synchronous FIFO buffering LIN TX payload words between the APB writer and
// the LIN transmit engine, with occupancy status, flush and sticky error flags.
module lin_tx_frame_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    lin_tx_frame_fifo_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_nxt;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              ovf_q;
    logic              unf_q;

    logic full;
    logic empty;
    logic rd_accept;
    logic wr_accept;
    logic ovf_set;
    logic unf_set;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Flush masks both ports; a read frees a slot, so a full FIFO still takes a write alongside it.
    assign rd_accept = bus.rd_en && !empty && !bus.flush;
    assign wr_accept = bus.wr_en && (!full || rd_accept) && !bus.flush;
    assign ovf_set   = bus.wr_en && full && !rd_accept && !bus.flush;
    assign unf_set   = bus.rd_en && empty && !bus.flush;

    always_comb begin
        count_nxt = count_q;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
    end

    // NOTE: the storage array has no reset branch so it maps onto plain RAM;
    // the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // NOTE: every register here uses <= so that a same-cycle write and read of
    // one slot (full FIFO) returns the old word, not the incoming one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                rd_data_q <= mem[rd_ptr];
            end
            rd_valid_q <= rd_accept;
            count_q    <= count_nxt;
        end
    end

    // Sticky flags: a new error in the clear cycle wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.err_clr) begin
                ovf_q <= 1'b0;
            end
            if (unf_set) begin
                unf_q <= 1'b1;
            end else if (bus.err_clr) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.count       = count_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = (count_q >= CNT_W'(AF_LVL));
    assign bus.ovf_err     = ovf_q;
    assign bus.unf_err     = unf_q;
endmodule
